// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage hazard bus: IF/ID instruction in, ALU forward selects, stall and bubble count out.
// The pipeline drives the master side; the hazard controller is the slave.
interface fwd_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_ir;
  logic             id_valid;
  logic             flush;
  logic [1:0]       fa;
  logic [1:0]       fb;
  logic             stall;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output id_ir, id_valid, flush,
    input  fa, fb, stall, bubble_count
  );

  modport slave (
    input  id_ir, id_valid, flush,
    output fa, fb, stall, bubble_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for a 5-stage MIPS pipeline.
// Decodes IF/ID one cycle ahead so fa/fb are registered and valid while the consumer is in EX.
module fwd_hazard_ctrl #(
  parameter logic [5:0] ALU_OP  = 6'd0,
  parameter logic [5:0] LW_OP   = 6'd35,
  parameter logic [5:0] SW_OP   = 6'd43,
  parameter logic [5:0] ADDI_OP = 6'd8,
  parameter logic [5:0] BEQ_OP  = 6'd4,
  parameter logic [5:0] J_OP    = 6'd2,
  parameter logic [5:0] JAL_OP  = 6'd3,
  parameter int         CNT_W   = 16
) (
  input  logic           clock,
  input  logic           reset,
  fwd_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] SEL_IDEX  = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt, w_rd;
  logic [4:0] w_dst;
  logic       w_wr_raw, w_wr, w_load, w_use_rs, w_use_rt;
  logic       w_stall, w_bubble;

  // Shadow copies of destination info; MEM/WB is never consulted because the
  // register file writes before it reads, so only ID/EX and EX/MEM are kept.
  logic             r_idex_wr, r_idex_load;
  logic [4:0]       r_idex_dst;
  logic             r_exmem_wr;
  logic [4:0]       r_exmem_dst;
  logic [1:0]       r_fa, r_fb;
  logic [CNT_W-1:0] r_bubble_count;

  assign w_op = bus.id_ir[31:26];
  assign w_rs = bus.id_ir[25:21];
  assign w_rt = bus.id_ir[20:16];
  assign w_rd = bus.id_ir[15:11];

  function automatic logic [1:0] fwd_sel(
    input logic       use_src,
    input logic [4:0] src,
    input logic       idex_wr,
    input logic [4:0] idex_dst,
    input logic       exmem_wr,
    input logic [4:0] exmem_dst
  );
    logic [1:0] sel;
    sel = SEL_IDEX;
    if (!use_src) begin
      sel = SEL_IDEX;
    end else if (idex_wr && (src == idex_dst)) begin
      sel = SEL_EXMEM;
    end else if (exmem_wr && (src == exmem_dst)) begin
      sel = SEL_MEMWB;
    end else begin
      sel = SEL_IDEX;
    end
    return sel;
  endfunction

  // Instruction decode: destination, write-enable, load flag and source usage.
  always_comb begin
    w_dst    = 5'd0;
    w_wr_raw = 1'b0;
    w_load   = 1'b0;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    case (w_op)
      ALU_OP:  begin w_dst = w_rd;  w_wr_raw = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; end
      LW_OP:   begin w_dst = w_rt;  w_wr_raw = 1'b1; w_load = 1'b1; w_use_rs = 1'b1; end
      SW_OP:   begin w_use_rs = 1'b1; w_use_rt = 1'b1; end
      ADDI_OP: begin w_dst = w_rt;  w_wr_raw = 1'b1; w_use_rs = 1'b1; end
      BEQ_OP:  begin w_use_rs = 1'b1; w_use_rt = 1'b1; end
      J_OP:    begin w_dst = 5'd0; end
      JAL_OP:  begin w_dst = 5'd31; w_wr_raw = 1'b1; end
      default: begin w_dst = 5'd0; end
    endcase
  end

  // r0 is hardwired: never a forwarding source nor a stall cause.
  assign w_wr = w_wr_raw & (w_dst != 5'd0);

  assign w_stall = bus.id_valid & ~bus.flush & r_idex_wr & r_idex_load &
                   ((w_use_rs & (w_rs == r_idex_dst)) | (w_use_rt & (w_rt == r_idex_dst)));
  assign w_bubble = w_stall | bus.flush | ~bus.id_valid;

  // Shadow pipeline advance, forward-select registers and bubble counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idex_wr      <= 1'b0;
      r_idex_load    <= 1'b0;
      r_idex_dst     <= 5'd0;
      r_exmem_wr     <= 1'b0;
      r_exmem_dst    <= 5'd0;
      r_fa           <= SEL_IDEX;
      r_fb           <= SEL_IDEX;
      r_bubble_count <= {CNT_W{1'b0}};
    end else begin
      r_exmem_wr  <= r_idex_wr;
      r_exmem_dst <= r_idex_dst;
      if (w_bubble) begin
        r_idex_wr   <= 1'b0;
        r_idex_load <= 1'b0;
        r_idex_dst  <= 5'd0;
        r_fa        <= SEL_IDEX;
        r_fb        <= SEL_IDEX;
      end else begin
        r_idex_wr   <= w_wr;
        r_idex_load <= w_load;
        r_idex_dst  <= w_dst;
        r_fa <= fwd_sel(w_use_rs, w_rs, r_idex_wr, r_idex_dst, r_exmem_wr, r_exmem_dst);
        r_fb <= fwd_sel(w_use_rt, w_rt, r_idex_wr, r_idex_dst, r_exmem_wr, r_exmem_dst);
      end
      if (w_stall && (r_bubble_count != {CNT_W{1'b1}})) begin
        r_bubble_count <= r_bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_bubble_count <= r_bubble_count;
      end
    end
  end

  assign bus.fa           = r_fa;
  assign bus.fb           = r_fb;
  assign bus.stall        = w_stall;
  assign bus.bubble_count = r_bubble_count;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed testbench for fwd_hazard_ctrl: hand-computed forward selects, stalls and bubble counts.
module tb_fwd_hazard_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  fwd_hazard_ctrl_if #(.CNT_W(16)) bus ();

  fwd_hazard_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] ir, input logic valid, input logic fl);
    bus.id_ir    = ir;
    bus.id_valid = valid;
    bus.flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.fa, bus.fb, bus.stall} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL reset_sel fa=%b fb=%b stall=%b required 00 00 0", bus.fa, bus.fb, bus.stall);
    end
    n_checks++;
    if (bus.bubble_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d required 0", bus.bubble_count);
    end
  endtask

  task automatic test_exmem_fwd();
    idle();
    drive(r_type(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0);
    tick();
    drive(r_type(5'd3, 5'd3, 5'd4, 6'h20), 1'b1, 1'b0);
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stall got %b required 0", bus.stall);
    end
    tick();
    n_checks++;
    if ({bus.fa, bus.fb} !== 4'b1010) begin
      n_fail++;
      $display("FAIL b2b_fwd fa=%b fb=%b required 10 10", bus.fa, bus.fb);
    end
  endtask

  task automatic test_memwb_fwd();
    idle();
    drive(r_type(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0);
    tick();
    drive(32'd0, 1'b0, 1'b0);
    tick();
    drive(r_type(5'd1, 5'd3, 5'd4, 6'h22), 1'b1, 1'b0);
    tick();
    n_checks++;
    if ({bus.fa, bus.fb} !== 4'b0001) begin
      n_fail++;
      $display("FAIL memwb_fwd fa=%b fb=%b required 00 01", bus.fa, bus.fb);
    end
  endtask

  task automatic test_priority();
    idle();
    drive(i_type(6'd8, 5'd1, 5'd3, 16'd7), 1'b1, 1'b0);
    tick();
    drive(r_type(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0);
    tick();
    drive(r_type(5'd3, 5'd0, 5'd5, 6'h20), 1'b1, 1'b0);
    tick();
    n_checks++;
    if ({bus.fa, bus.fb} !== 4'b1000) begin
      n_fail++;
      $display("FAIL priority fa=%b fb=%b required 10 00", bus.fa, bus.fb);
    end
  endtask

  task automatic test_load_use();
    idle();
    drive(i_type(6'd35, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
    tick();
    drive(r_type(5'd5, 5'd1, 5'd6, 6'h20), 1'b1, 1'b0);
    n_checks++;
    if (bus.stall !== 1'b1 || bus.bubble_count !== 16'd0) begin
      n_fail++;
      $display("FAIL lu_stall stall=%b count=%0d required 1 0", bus.stall, bus.bubble_count);
    end
    tick();
    n_checks++;
    if (bus.stall !== 1'b0 || bus.bubble_count !== 16'd1 || {bus.fa, bus.fb} !== 4'b0000) begin
      n_fail++;
      $display("FAIL lu_bubble stall=%b count=%0d fa=%b fb=%b required 0 1 00 00",
               bus.stall, bus.bubble_count, bus.fa, bus.fb);
    end
    tick();
    n_checks++;
    if ({bus.fa, bus.fb} !== 4'b0100 || bus.bubble_count !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_fwd fa=%b fb=%b count=%0d required 01 00 1", bus.fa, bus.fb, bus.bubble_count);
    end
  endtask

  task automatic test_r0();
    idle();
    drive(r_type(5'd1, 5'd2, 5'd0, 6'h20), 1'b1, 1'b0);
    tick();
    drive(r_type(5'd0, 5'd0, 5'd4, 6'h20), 1'b1, 1'b0);
    tick();
    n_checks++;
    if ({bus.fa, bus.fb} !== 4'b0000) begin
      n_fail++;
      $display("FAIL r0_alu fa=%b fb=%b required 00 00", bus.fa, bus.fb);
    end
    drive(i_type(6'd35, 5'd1, 5'd0, 16'd4), 1'b1, 1'b0);
    tick();
    drive(r_type(5'd0, 5'd0, 5'd4, 6'h20), 1'b1, 1'b0);
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_load_stall got %b required 0", bus.stall);
    end
    tick();
    n_checks++;
    if ({bus.fa, bus.fb} !== 4'b0000 || bus.bubble_count !== 16'd1) begin
      n_fail++;
      $display("FAIL r0_load_fwd fa=%b fb=%b count=%0d required 00 00 1", bus.fa, bus.fb, bus.bubble_count);
    end
  endtask

  task automatic test_flush();
    idle();
    drive(i_type(6'd35, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
    tick();
    drive(r_type(5'd5, 5'd5, 5'd6, 6'h20), 1'b1, 1'b1);
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall got %b required 0", bus.stall);
    end
    tick();
    n_checks++;
    if (bus.bubble_count !== 16'd1 || {bus.fa, bus.fb} !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_result count=%0d fa=%b fb=%b required 1 00 00", bus.bubble_count, bus.fa, bus.fb);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    drive(i_type(6'd35, 5'd1, 5'd8, 16'd0), 1'b1, 1'b0);
    tick();
    drive(i_type(6'd43, 5'd2, 5'd8, 16'd4), 1'b1, 1'b0);
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_stall got %b required 1", bus.stall);
    end
    tick();
    tick();
    n_checks++;
    if ({bus.fa, bus.fb} !== 4'b0001 || bus.bubble_count !== 16'd2) begin
      n_fail++;
      $display("FAIL sw_fwd fa=%b fb=%b count=%0d required 00 01 2", bus.fa, bus.fb, bus.bubble_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    drive(r_type(5'd1, 5'd2, 5'd7, 6'h20), 1'b1, 1'b0);
    tick();
    drive(i_type(6'd35, 5'd7, 5'd5, 16'd0), 1'b1, 1'b0);
    tick();
    drive(r_type(5'd5, 5'd7, 5'd6, 6'h20), 1'b1, 1'b0);
    n_checks++;
    if (bus.stall !== 1'b1 || bus.fa !== 2'b10) begin
      n_fail++;
      $display("FAIL pre_reset stall=%b fa=%b required 1 10", bus.stall, bus.fa);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.fa, bus.fb, bus.stall} !== 5'b0_0000 || bus.bubble_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset fa=%b fb=%b stall=%b count=%0d required 00 00 0 0",
               bus.fa, bus.fb, bus.stall, bus.bubble_count);
    end
    tick();
    reset = 1'b0;
    #1;
    tick();
    n_checks++;
    if ({bus.fa, bus.fb, bus.stall} !== 5'b0_0000 || bus.bubble_count !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset fa=%b fb=%b stall=%b count=%0d required 00 00 0 0",
               bus.fa, bus.fb, bus.stall, bus.bubble_count);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.id_ir    = 32'd0;
    bus.id_valid = 1'b0;
    bus.flush    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    test_reset();
    test_exmem_fwd();
    test_memwb_fwd();
    test_priority();
    test_load_use();
    test_r0();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
